// File: rtl/serial_tx_if.sv
// Handshake and line signals of the single-wire frame transmitter.
// master drives the word and VALID; slave is the transmitter.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_tx_frame.sv
// Parallel-in/serial-out frame transmitter: start bit, DATA_W bits LSB first, stop bit.
// Defining SERIAL_TX_PARITY_EN inserts an even-parity bit between the data and the stop bit.
//
// state    | meaning
// ---------+--------------------------------------------------
// S_IDLE   | line high, READY=1, waiting for VALID
// S_START  | start bit (TX=0) for CLKS_PER_BIT cycles
// S_DATA   | TX=shift[0], one bit per CLKS_PER_BIT cycles
// S_PARITY | even parity of the loaded word (parity build only)
// S_STOP   | stop bit (TX=1) for CLKS_PER_BIT cycles
module serial_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input logic        clk,
  input logic        rst,
  serial_tx_if.slave bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              cyc_last;
  logic              bit_last;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign cyc_last = (cyc_q == CYC_LAST);
  assign bit_last = (bit_q == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.valid) begin
          state_d = S_START;
          shift_d = bus.data_in;
          cyc_d   = '0;
          bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
          // Parity is taken from the word as loaded; the shift register is consumed later.
          par_d   = ^bus.data_in;
`endif
        end
      end
      S_START: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = S_DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cyc_last) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_last) begin
            bit_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = S_STOP;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (cyc_last) begin
          cyc_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // TX is registered from the next state so the line never glitches between bits.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.tx    = tx_q;
  assign bus.done  = done_q;

endmodule
